// File: rtl/saber_mult_pkg.sv
// Shared constants and types for the Saber negacyclic MAC engine.
package saber_mult_pkg;

  localparam int N_DEF     = 256;
  localparam int QW_DEF    = 13;
  localparam int SW_DEF    = 4;
  localparam int CNT_W_DEF = $clog2(N_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of broadcast multiples of a_coeff (0 .. 2^(SW-1)-1).
  function automatic int num_mult(input int sw);
    return 1 << (sw - 1);
  endfunction

endpackage

// File: rtl/saber_mac_lane.sv
// One MAC lane: acc + a*rot mod 2^QW, built from the broadcast multiples of a
// by magnitude select followed by an optional negate.
module saber_mac_lane
  import saber_mult_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int SW = SW_DEF,
  localparam int NM = 1 << (SW - 1)
) (
  input  logic [QW-1:0]    acc_i,
  input  logic [SW-1:0]    rot_i,
  input  logic [NM*QW-1:0] mult_i,
  output logic [QW-1:0]    acc_o
);

  logic [QW-1:0] mtab [NM];
  logic          neg;
  logic [SW-2:0] mag;
  logic [QW-1:0] prod;
  logic [QW-1:0] term;

  for (genvar k = 0; k < NM; k++) begin : g_unpack
    assign mtab[k] = mult_i[k*QW +: QW];
  end

  // |rot| never exceeds 2^(SW-1)-1, so the magnitude fits SW-1 bits and the
  // two's-complement sign can be reapplied after the table lookup.
  always_comb begin
    neg   = rot_i[SW-1];
    mag   = neg ? (SW-1)'(-rot_i) : rot_i[SW-2:0];
    prod  = mtab[mag];
    term  = neg ? -prod : prod;
    acc_o = acc_i + term;
  end

endmodule

// File: rtl/saber_poly_mac_engine.sv
// Sequential negacyclic polynomial MAC: acc <- acc + a*s mod (x^N+1, 2^QW).
// The secret is loaded in parallel and rotated by x each accepted beat while
// a is streamed one coefficient per beat.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for start; result holds the last accumulator value
//   RUN     | a_ready=1; each beat does one MAC across all lanes + rotate
//   DONE    | one-cycle done pulse, then back to IDLE
module saber_poly_mac_engine
  import saber_mult_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int QW = QW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode_acc,
  input  logic [N*SW-1:0]   secret_in,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [QW-1:0]     a_coeff,
  output logic              busy,
  output logic              done,
  output logic [N*QW-1:0]   result
);

  localparam int CW = $clog2(N);
  localparam int NM = 1 << (SW - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N*SW-1:0]   rot_q, rot_d;
  logic [N*QW-1:0]   acc_q, acc_d;

  logic [NM*QW-1:0]  mult;
  logic [N*QW-1:0]   acc_mac;
  logic [N*SW-1:0]   rot_shift;

  // Multiples 0..NM-1 of the incoming coefficient, shared by every lane.
  always_comb begin
    mult = '0;
    for (int k = 0; k < NM; k++) begin
      mult[k*QW +: QW] = a_coeff * QW'(k);
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    saber_mac_lane #(
      .QW (QW),
      .SW (SW)
    ) u_lane (
      .acc_i  (acc_q[j*QW +: QW]),
      .rot_i  (rot_q[j*SW +: SW]),
      .mult_i (mult),
      .acc_o  (acc_mac[j*QW +: QW])
    );
  end

  // Multiply by x in Z[x]/(x^N+1): shift up one coefficient, top wraps negated.
  assign rot_shift = {rot_q[(N-1)*SW-1:0], -rot_q[N*SW-1 -: SW]};

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    acc_d   = acc_q;
    a_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rot_d   = secret_in;
          cnt_d   = '0;
          state_d = ST_RUN;
          if (!mode_acc) begin
            acc_d = '0;
          end
        end
      end
      ST_RUN: begin
        a_ready = 1'b1;
        busy    = 1'b1;
        if (a_valid) begin
          acc_d = acc_mac;
          rot_d = rot_shift;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, rotating secret and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rot_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
      acc_q   <= acc_d;
    end
  end

  assign result = acc_q;

endmodule
